tff_mod_counter: RTL
====================

# tff_mod_counter

Synchronous modulo-N up/down counter that generates the per-bit toggle vector for a bank of T flip-flops. It sits directly upstream of the `stff` toggle stage: each cycle it computes which bits must toggle to reach the next count, presents that vector on `t`, and keeps its own mirror of the count. It also provides terminal-count, wrap and load-error flags for the surrounding datapath.

## Interface
- `WIDTH`, 4, count width in bits (2..16)
- `MODULUS`, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH
- `clk`  in  1  clock; all state updates on the rising edge
- `clrn`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable
- `up`  in  1  direction: 1 counts up, 0 counts down (see Configuration)
- `ld`  in  1  synchronous load request
- `d`  in  WIDTH  load value
- `q`  out  WIDTH  current count, registered
- `t`  out  WIDTH  toggle vector for the downstream T flip-flops, combinational
- `tc`  out  1  terminal count, combinational
- `wrap`  out  1  one-cycle pulse, registered; count wrapped on the previous edge
- `err`  out  1  one-cycle pulse, registered; illegal load rejected on the previous edge

## Operation
- Reset (`clrn`=0, asynchronous): `q`=0, `wrap`=0, `err`=0. `t` is forced to 0 while `clrn`=0. Reset overrides everything; asserting it mid-count aborts the count immediately, with no edge required.
- Next-state priority on each rising edge: `ld`, then `en`, then hold.
- Legal load (`ld`=1, `d` < MODULUS): `q` <= `d`; `wrap` <= 0; `err` <= 0.
- Illegal load (`ld`=1, `d` >= MODULUS): `q` holds; `err` <= 1; the `en` request for that cycle is discarded.
- Count up (`ld`=0, `en`=1, `up`=1): `q` <= `q`+1. If `q`==MODULUS-1, `q` <= 0 instead and `wrap` <= 1.
- Count down (`ld`=0, `en`=1, `up`=0): `q` <= `q`-1. If `q`==0, `q` <= MODULUS-1 instead and `wrap` <= 1.
- Hold (`ld`=0, `en`=0): `q` holds.
- `wrap` and `err` are 0 on every edge where their condition is not met. Both are single-cycle pulses.
- Toggle vector: `t` = `q` XOR next-state(`q`). It is 0 on hold and 0 on an illegal load, so `q` XOR `t` always equals the value `q` takes on the next edge.
- `tc` = `en` & !`ld` & ((`up` & `q`==MODULUS-1) | (!`up` & `q`==0)).
- Arithmetic is unsigned at WIDTH bits. When MODULUS=2^WIDTH, wrap falls out of natural overflow but is still flagged.

## Timing
- Latency: one edge from request to `q`. `t` and `tc` are valid in the same cycle as their inputs.
- `wrap` and `err` are asserted for exactly the cycle following the causing edge.
- Simultaneous `ld` and `en`: the load wins. No `wrap` is generated, even if the count was at terminal.
- Direction changes take effect on the next edge, with no pipeline bubble.
- Reset release: the first edge with `clrn`=1 is a normal operating edge.

## Configuration
- `TFF_MOD_COUNTER_UPDOWN_EN` defined: direction is controlled by `up`, as described above.
- `TFF_MOD_COUNTER_UPDOWN_EN` undefined:
  - The `up` port is present but ignored; the counter is up-only.
  - `tc` reduces to `en` & !`ld` & `q`==MODULUS-1.
  - Down-count logic is not synthesized.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 with `TFF_MOD_COUNTER_UPDOWN_EN` defined unless stated.
- Reset: hold `clrn`=0 with `en`=1 for 3 edges -> `q`=0, `t`=0, `wrap`=0, `err`=0 throughout. Release -> first edge gives `q`=1.
- Up wrap: load 8, then `en`=1, `up`=1 for 2 edges -> `q` sequence 8,9,0. `tc`=1 while `q`=9, with `t`=4'b1001. `wrap`=1 for the one cycle after `q` becomes 0.
- Down wrap: load 1, then `up`=0 for 2 edges -> `q` sequence 1,0,9. `t`=4'b1001 at `q`=0. `wrap` pulses once.
- Illegal load: `q`=5, `ld`=1, `d`=12, `en`=1 -> `q` stays 5, `t`=0, `err`=1 for one cycle. Next edge with `ld`=0 gives `q`=6.
- Load vs count at terminal: `q`=9, `ld`=1, `d`=3, `en`=1 -> `q`=3, `wrap`=0, `tc`=0.
- Async reset mid-count: assert `clrn`=0 between edges at `q`=7 -> `q`=0 before the next edge. Then rebuild without the macro and drive `up`=0 from `q`=9 -> `q`=0 with a `wrap` pulse (up-only behaviour).

Source files
------------

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS counter that drives a T flip-flop bank with its per-bit toggle vector.
// Define TFF_MOD_COUNTER_UPDOWN_EN to enable down-counting via `up`; otherwise up-only.
module tff_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_d;
  logic             wrap_d;
  logic             err_d;
  logic             d_legal;
  logic             at_top;
  logic             term;

  assign d_legal = (32'(d) < MODULUS);
  assign at_top  = (q == MaxCount);

`ifdef TFF_MOD_COUNTER_UPDOWN_EN
  logic at_bottom;

  assign at_bottom = (q == '0);
  assign term      = up ? at_top : at_bottom;
`else
  logic unused_up;

  assign unused_up = up;
  assign term      = at_top;
`endif

  // Load beats count; an illegal load also swallows that cycle's count request.
  always_comb begin
    q_d    = q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (ld) begin
      if (d_legal) begin
        q_d = d;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
`ifdef TFF_MOD_COUNTER_UPDOWN_EN
      if (up) begin
        q_d = at_top ? '0 : q + 1'b1;
      end else begin
        q_d = at_bottom ? MaxCount : q - 1'b1;
      end
`else
      q_d = at_top ? '0 : q + 1'b1;
`endif
      wrap_d = term;
    end
  end

  assign tc = en & ~ld & term;
  assign t  = clrn ? (q ^ q_d) : '0;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q    <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_d;
      wrap <= wrap_d;
      err  <= err_d;
    end
  end

endmodule
